// File: rtl/xform_pkg.sv
// Shared defaults and the sequencer state type for the matrix-transform front end.
package xform_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_LANES      = 4;
   localparam int DEF_ROWS       = 3;
   localparam int DEF_CNT_WIDTH  = 16;
   localparam int DEF_BEAT_W     = DEF_LANES * DEF_DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep valid/ready register slice with a tlast sideband.
module axis_reg_slice #(
   parameter int W = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] s_data_i,
   input  logic         s_valid_i,
   input  logic         s_last_i,
   output logic         s_ready_o,
   output logic [W-1:0] m_data_o,
   output logic         m_valid_o,
   output logic         m_last_o,
   input  logic         m_ready_i
);

   logic [W-1:0] data_q;
   logic         valid_q;
   logic         last_q;

   // A transfer happens on an edge where valid and ready are both high; a held
   // beat never changes while its consumer stalls.
   assign s_ready_o = !valid_q || m_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (s_valid_i && s_ready_o) begin
         data_q  <= s_data_i;
         valid_q <= 1'b1;
         last_q  <= s_last_i;
      end else if (m_ready_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

   assign m_data_o  = data_q;
   assign m_valid_o = valid_q;
   assign m_last_o  = last_q;

endmodule

// File: rtl/xform_frame_ctrl.sv
// Frame sequencer: loads the matrix rows into the coefficient bank, forwards
// vector beats to the datapath and waits for its final result before the next frame.
module xform_frame_ctrl
   import xform_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LANES      = DEF_LANES,
   parameter int ROWS       = DEF_ROWS,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                               aclk,
   input  logic                               aresetn,
   input  logic [LANES*DATA_WIDTH-1:0]        s_axis_tdata,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   input  logic                               s_axis_tlast,
   output logic [ROWS*LANES*DATA_WIDTH-1:0]   coef_data,
   output logic                               coef_valid,
   output logic [LANES*DATA_WIDTH-1:0]        dp_tdata,
   output logic                               dp_tvalid,
   input  logic                               dp_tready,
   output logic                               dp_tlast,
   input  logic                               dp_done,
   output logic                               busy,
   output logic [CNT_WIDTH-1:0]               frame_cnt,
   output logic                               err_short,
   input  logic                               err_clr,
   output logic [1:0]                         dbg_state
);

   localparam int BEAT_W = LANES * DATA_WIDTH;
   localparam int RCW    = $clog2(ROWS);
   localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);

   state_t              state_q, state_d;
   logic [RCW-1:0]      row_cnt_q, row_cnt_d;
   logic [BEAT_W-1:0]   coef_q [ROWS];
   logic [BEAT_W-1:0]   coef_d [ROWS];
   logic                coef_valid_q, coef_valid_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                err_q, err_d, err_set;
   logic                done_q, done_d;
   logic                accept;
   logic                slice_valid, slice_ready;

   assign s_axis_tready = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                          ((state_q == ST_STREAM) && slice_ready);
   assign accept = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_d      = state_q;
      row_cnt_d    = row_cnt_q;
      coef_d       = coef_q;
      coef_valid_d = coef_valid_q;
      cnt_d        = cnt_q;
      done_d       = done_q;
      err_set      = 1'b0;
      slice_valid  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            done_d = 1'b0;
            if (accept) begin
               coef_d[0]    = s_axis_tdata;
               row_cnt_d    = RCW'(1);
               coef_valid_d = 1'b0;
               if (s_axis_tlast) err_set = 1'b1;
               else              state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               coef_d[row_cnt_q] = s_axis_tdata;
               row_cnt_d         = row_cnt_q + RCW'(1);
               if (row_cnt_q == LAST_ROW) begin
                  coef_valid_d = 1'b1;
                  if (s_axis_tlast) begin
                     // configuration-only frame: counts as complete, no vectors
                     cnt_d   = cnt_q + CNT_WIDTH'(1);
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_STREAM;
                  end
               end else if (s_axis_tlast) begin
                  err_set = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_STREAM: begin
            slice_valid = s_axis_tvalid;
            if (dp_done) done_d = 1'b1;
            if (accept && s_axis_tlast) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (dp_done) done_d = 1'b1;
            if (!dp_tvalid && done_q) begin
               cnt_d   = cnt_q + CNT_WIDTH'(1);
               done_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // a new short-frame event wins over a simultaneous clear
      err_d = err_set | (err_q & ~err_clr);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         row_cnt_q    <= '0;
         coef_q       <= '{default: '0};
         coef_valid_q <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_cnt_q    <= row_cnt_d;
         coef_q       <= coef_d;
         coef_valid_q <= coef_valid_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         done_q       <= done_d;
      end
   end

   axis_reg_slice #(.W(BEAT_W)) u_slice (
      .clk_i     (aclk),
      .rst_ni    (aresetn),
      .s_data_i  (s_axis_tdata),
      .s_valid_i (slice_valid),
      .s_last_i  (s_axis_tlast),
      .s_ready_o (slice_ready),
      .m_data_o  (dp_tdata),
      .m_valid_o (dp_tvalid),
      .m_last_o  (dp_tlast),
      .m_ready_i (dp_tready)
   );

   for (genvar r = 0; r < ROWS; r++) begin : g_coef
      assign coef_data[r*BEAT_W +: BEAT_W] = coef_q[r];
   end

   assign coef_valid = coef_valid_q;
   assign frame_cnt  = cnt_q;
   assign err_short  = err_q;
   assign busy       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: doc/xform_frame_ctrl.md
Name: xform_frame_ctrl

Overview:
- Front-end sequencer for the 4-lane matrix-transform datapath.
- Parses each input AXIS frame: the first ROWS beats are matrix rows, the remaining beats are vectors, and tlast ends the frame.
- Latches the matrix rows into a coefficient bank that drives the datapath, and forwards vector beats through a one-deep register slice.
- Holds off the next frame until the datapath reports that its last result has left.

Parameters:
- DATA_WIDTH, 16, width of one lane (Q-format, signed).
- LANES, 4, lanes per beat.
- ROWS, 3, matrix rows per frame (must be at least 2).
- CNT_WIDTH, 16, width of the frame counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  LANES*DATA_WIDTH  input beat; lane 0 in the LSBs.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of frame.
- coef_data  out  ROWS*LANES*DATA_WIDTH  coefficient bank; row r at bits [(r+1)*LANES*DATA_WIDTH-1 : r*LANES*DATA_WIDTH].
- coef_valid  out  1  bank holds a complete, stable matrix.
- dp_tdata  out  LANES*DATA_WIDTH  vector beat to the datapath.
- dp_tvalid  out  1  vector valid.
- dp_tready  in  1  datapath ready.
- dp_tlast  out  1  last vector of the frame.
- dp_done  in  1  single-cycle pulse when the datapath emits its final result (its m_tlast beat).
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  CNT_WIDTH  frames completed; wraps modulo 2^CNT_WIDTH.
- err_short  out  1  sticky flag: frame ended before the matrix was complete.
- err_clr  in  1  clears err_short.

Behaviour:
- Reset values:
  - State IDLE; coef_data all zeros; coef_valid=0.
  - dp_tvalid=0, dp_tlast=0, dp_tdata=0.
  - frame_cnt=0, err_short=0, busy=0, done_seen=0.
- States: IDLE, LOAD, STREAM, DRAIN. A beat is accepted when s_axis_tvalid and s_axis_tready are both high.
- IDLE:
  - s_axis_tready=1.
  - On an accepted beat: write row 0, set row_cnt=1, clear coef_valid, go to LOAD.
  - If that beat also has tlast: set err_short and stay in IDLE.
- LOAD:
  - s_axis_tready=1; each accepted beat writes row row_cnt.
  - tlast on a row index below ROWS-1: set err_short, leave coef_valid=0, go to IDLE.
  - Row ROWS-1 accepted without tlast: set coef_valid=1 on the next edge, go to STREAM.
  - Row ROWS-1 accepted with tlast (configuration-only frame): set coef_valid=1, increment frame_cnt, go to IDLE. No dp beat is produced.
- STREAM:
  - Register slice with s_axis_tready = !dp_tvalid || dp_tready.
  - An accepted beat loads dp_tdata/dp_tlast and sets dp_tvalid on the next edge, giving 1-cycle latency.
  - dp_tvalid clears on a dp handshake with no new input.
  - Full throughput when dp_tready stays high.
  - While dp_tvalid && !dp_tready, the registered dp_tdata, dp_tvalid and dp_tlast stay stable.
  - The tlast beat is accepted, then the state goes to DRAIN.
- DRAIN:
  - s_axis_tready=0.
  - Leave for IDLE when dp_tvalid==0 and done_seen==1; frame_cnt increments on that transition.
- done_seen:
  - Set by dp_done in STREAM or DRAIN, including a pulse in the same cycle as the tlast acceptance.
  - Cleared on entry to IDLE.
  - dp_done in IDLE or LOAD is ignored.
- Coefficients:
  - coef_data changes only on row writes.
  - coef_valid stays 1 through DRAIN and IDLE until row 0 of the next frame is written.
- err_short: a set event and err_clr in the same cycle leave it set. Otherwise err_clr clears it.
- busy = (state != IDLE).
- Asserting aresetn low mid-frame returns everything to reset values immediately. Beats in flight are dropped.

Decomposition:
- Package xform_pkg holds:
  - DATA_WIDTH, LANES, ROWS defaults;
  - the state enum (IDLE, LOAD, STREAM, DRAIN);
  - the beat-width localparam.
- One sub-module, axis_reg_slice: the one-deep valid/ready register with a tlast sideband, reused by other stream blocks.

Test Plan:
- Matrix load:
  - Stimulus: rows {41,0,0,-20480}, {0,41,0,-16384}, {0,0,41,-17613}, then 12 vectors with tlast on the 12th, dp_tready=1.
  - Response: coef_valid rises 1 cycle after row 2; coef_data equals the three rows; 12 dp beats with dp_tdata[15:0]=25 on the first beat and dp_tlast only on the 12th.
- Completion:
  - Stimulus: same frame, dp_done pulsed 5 cycles after the last dp beat.
  - Response: busy stays 1 until the cycle after dp_done, then frame_cnt=1 and the state is IDLE.
- Backpressure:
  - Stimulus: dp_tready toggles 1,0,0,1 repeatedly during STREAM.
  - Response: no beat lost or duplicated; dp_tdata stable while stalled; s_axis_tready=0 whenever dp_tvalid && !dp_tready.
- Short frame:
  - Stimulus: 2 matrix beats with tlast on the 2nd.
  - Response: err_short=1, coef_valid=0, no dp beats. Pulsing err_clr clears the flag; a following good frame runs normally.
- Configuration-only frame:
  - Stimulus: 3 beats with tlast on the 3rd.
  - Response: coef_valid=1, frame_cnt increments, dp_tvalid never rises.
- Back-to-back frames and reset:
  - Stimulus: a second identical frame starts 50 cycles after the first, then reset is asserted during its 5th vector.
  - Response: the second frame completes with frame_cnt=2; the reset clears all outputs to reset values within the same cycle.
